// File: rtl/input_conditioner_if.sv
// Purpose: signal bundle between the board-facing button conditioner and its user.
//   i_key_n     : raw active-low buttons [0]=right [1]=left [2]=jump [3]=squat
//                 [4]=attack [5]=defend [6]=select, asynchronous to clk
//   i_is_gaming : game controller is in the play state
//   o_right, o_left, o_squat, o_defend : level actions
//   o_jump, o_attack, o_select         : one-cycle action pulses
// The master side drives the raw inputs and consumes the actions; the slave
// side is the conditioner itself.
interface input_conditioner_if;
    logic [6:0] i_key_n;
    logic       i_is_gaming;
    logic       o_right;
    logic       o_left;
    logic       o_jump;
    logic       o_squat;
    logic       o_attack;
    logic       o_defend;
    logic       o_select;

    modport master (
        output i_key_n,
        output i_is_gaming,
        input  o_right,
        input  o_left,
        input  o_jump,
        input  o_squat,
        input  o_attack,
        input  o_defend,
        input  o_select
    );

    modport slave (
        input  i_key_n,
        input  i_is_gaming,
        output o_right,
        output o_left,
        output o_jump,
        output o_squat,
        output o_attack,
        output o_defend,
        output o_select
    );
endinterface

// File: rtl/input_conditioner.sv
// Purpose: turns raw bouncing active-low buttons into game-ready actions.
//   Each key is synchronized (2 flops), debounced (DEBOUNCE_CYCLES stable cycles),
//   then mapped to level outputs (right/left/squat/defend) or single-cycle press
//   pulses (jump/attack/select). Attack is rate-limited by ATTACK_COOLDOWN cycles.
//   Gameplay actions are suppressed while i_is_gaming is low; select is not.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : input_conditioner_if.slave (raw keys + play state in, actions out)
// All actions are registered; a clean raw edge sampled at edge 0 appears on the
// outputs at edge DEBOUNCE_CYCLES+2 for every channel.
module input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned ATTACK_COOLDOWN = 12500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input_conditioner_if.slave  bus
);

    localparam int unsigned NUM_KEYS = 7;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned CD_W     = $clog2(ATTACK_COOLDOWN + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(ATTACK_COOLDOWN);

    localparam int unsigned K_RIGHT  = 0;
    localparam int unsigned K_LEFT   = 1;
    localparam int unsigned K_JUMP   = 2;
    localparam int unsigned K_SQUAT  = 3;
    localparam int unsigned K_ATTACK = 4;
    localparam int unsigned K_DEFEND = 5;
    localparam int unsigned K_SELECT = 6;

    // Synchronizer and debounce state
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [NUM_KEYS-1:0] r_stable_d;
    logic [DB_W-1:0]     r_db_cnt [NUM_KEYS];

    // Attack rate limiter
    logic [CD_W-1:0]     r_cooldown;

    // Registered actions
    logic r_right;
    logic r_left;
    logic r_jump;
    logic r_squat;
    logic r_attack;
    logic r_defend;
    logic r_select;

    // Next-state / combinational terms
    logic [NUM_KEYS-1:0] w_stable_nxt;
    logic [DB_W-1:0]     w_db_cnt_nxt [NUM_KEYS];
    logic [NUM_KEYS-1:0] w_pressed;
    logic [NUM_KEYS-1:0] w_press_edge;
    logic                w_cd_idle;
    logic                w_attack_fire;
    logic [CD_W-1:0]     w_cooldown_nxt;
    logic                w_right_nxt;
    logic                w_left_nxt;
    logic                w_jump_nxt;
    logic                w_squat_nxt;
    logic                w_attack_nxt;
    logic                w_defend_nxt;
    logic                w_select_nxt;

    // Two-flop synchronizer; idle (released) level is 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Per-channel debounce: count consecutive disagreeing cycles, accept on the last one
    always_comb begin
        w_stable_nxt = r_stable;
        w_db_cnt_nxt = r_db_cnt;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (r_sync2[i] == r_stable[i]) begin
                w_db_cnt_nxt[i] = '0;
            end else if (r_db_cnt[i] == DB_LAST) begin
                w_stable_nxt[i] = r_sync2[i];
                w_db_cnt_nxt[i] = '0;
            end else begin
                w_db_cnt_nxt[i] = r_db_cnt[i] + DB_W'(1);
            end
        end
    end

    // Debounce state register; r_stable_d holds last cycle's stable for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable   <= '1;
            r_stable_d <= '1;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_stable   <= w_stable_nxt;
            r_stable_d <= r_stable;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                r_db_cnt[i] <= w_db_cnt_nxt[i];
            end
        end
    end

    // Action decode from the debounced state
    always_comb begin
        w_pressed      = ~r_stable;
        // newly pressed: pressed now, released (stable high) last cycle
        w_press_edge   = w_pressed & r_stable_d;
        w_cd_idle      = (r_cooldown == '0);
        w_attack_fire  = w_press_edge[K_ATTACK] & bus.i_is_gaming & w_cd_idle;

        // Leaving the play state cancels any pending cooldown
        w_cooldown_nxt = r_cooldown;
        if (!bus.i_is_gaming) begin
            w_cooldown_nxt = '0;
        end else if (w_attack_fire) begin
            w_cooldown_nxt = CD_LOAD;
        end else if (!w_cd_idle) begin
            w_cooldown_nxt = r_cooldown - CD_W'(1);
        end

        // Opposing directions cancel each other
        w_right_nxt  = w_pressed[K_RIGHT] & ~w_pressed[K_LEFT]  & bus.i_is_gaming;
        w_left_nxt   = w_pressed[K_LEFT]  & ~w_pressed[K_RIGHT] & bus.i_is_gaming;
        w_squat_nxt  = w_pressed[K_SQUAT]  & bus.i_is_gaming;
        w_defend_nxt = w_pressed[K_DEFEND] & bus.i_is_gaming;
        w_jump_nxt   = w_press_edge[K_JUMP] & bus.i_is_gaming;
        w_attack_nxt = w_attack_fire;
        // Select drives menu states too, so it ignores the play state
        w_select_nxt = w_press_edge[K_SELECT];
    end

    // Output and cooldown registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cooldown <= '0;
            r_right    <= 1'b0;
            r_left     <= 1'b0;
            r_jump     <= 1'b0;
            r_squat    <= 1'b0;
            r_attack   <= 1'b0;
            r_defend   <= 1'b0;
            r_select   <= 1'b0;
        end else begin
            r_cooldown <= w_cooldown_nxt;
            r_right    <= w_right_nxt;
            r_left     <= w_left_nxt;
            r_jump     <= w_jump_nxt;
            r_squat    <= w_squat_nxt;
            r_attack   <= w_attack_nxt;
            r_defend   <= w_defend_nxt;
            r_select   <= w_select_nxt;
        end
    end

    assign bus.o_right  = r_right;
    assign bus.o_left   = r_left;
    assign bus.o_jump   = r_jump;
    assign bus.o_squat  = r_squat;
    assign bus.o_attack = r_attack;
    assign bus.o_defend = r_defend;
    assign bus.o_select = r_select;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with DEBOUNCE_CYCLES=4, ATTACK_COOLDOWN=10.
// A sample-history model predicts every output each cycle; directed scenarios
// add literal expectations at the cycles worked out by hand.
module tb_input_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned CD = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    input_conditioner_if bus ();

    input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .ATTACK_COOLDOWN (CD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // raw_q[e] is the raw key vector sampled at post-reset edge e. The second
    // synchronizer flop presents raw_q[e-2] at edge e (all released before that).
    // A key's accepted state flips once DB consecutive presented samples all
    // disagree with it. Actions at edge k follow from the accepted state after
    // edges k-1 and k-2 and from i_is_gaming sampled at edge k.
    logic [6:0] raw_q [$];
    logic [6:0] m_stable, m_stable_prev;
    logic [6:0] m_pr, m_prev_pr, m_pe, m_s;
    logic       m_right, m_left, m_jump, m_squat, m_attack, m_defend, m_select;
    logic       m_g, m_all_diff;
    int         m_edge, m_last_fire;
    bit         m_fired;

    function automatic logic [6:0] sync2_at(input int e);
        if (e >= 2) return raw_q[e-2];
        return 7'h7F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q.delete();
            m_stable = 7'h7F; m_stable_prev = 7'h7F;
            m_right = 0; m_left = 0; m_jump = 0; m_squat = 0;
            m_attack = 0; m_defend = 0; m_select = 0;
            m_fired = 0; m_last_fire = 0; m_edge = 0;
        end else begin
            m_g       = bus.i_is_gaming;
            m_pr      = ~m_stable;
            m_prev_pr = ~m_stable_prev;
            m_pe      = m_pr & ~m_prev_pr;
            m_right   = m_pr[0] & !m_pr[1] & m_g;
            m_left    = m_pr[1] & !m_pr[0] & m_g;
            m_squat   = m_pr[3] & m_g;
            m_defend  = m_pr[5] & m_g;
            m_jump    = m_pe[2] & m_g;
            m_select  = m_pe[6];
            // attack allowed once CD full cycles have passed since the last one
            m_attack  = m_pe[4] & m_g & (!m_fired || (m_edge >= m_last_fire + int'(CD) + 1));
            if (m_attack) begin
                m_fired = 1; m_last_fire = m_edge;
            end
            if (!m_g) m_fired = 0;
            raw_q.push_back(bus.i_key_n);
            m_stable_prev = m_stable;
            for (int b = 0; b < 7; b++) begin
                m_all_diff = 1;
                for (int j = 0; j < int'(DB); j++) begin
                    if (m_edge - j < 0) m_all_diff = 0;
                    else begin
                        m_s = sync2_at(m_edge - j);
                        if (m_s[b] == m_stable_prev[b]) m_all_diff = 0;
                    end
                end
                if (m_all_diff) m_stable[b] = ~m_stable_prev[b];
            end
            m_edge++;
        end
    end

    // Per-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("cmp_right",  int'(bus.o_right),  int'(m_right));
            chk("cmp_left",   int'(bus.o_left),   int'(m_left));
            chk("cmp_jump",   int'(bus.o_jump),   int'(m_jump));
            chk("cmp_squat",  int'(bus.o_squat),  int'(m_squat));
            chk("cmp_attack", int'(bus.o_attack), int'(m_attack));
            chk("cmp_defend", int'(bus.o_defend), int'(m_defend));
            chk("cmp_select", int'(bus.o_select), int'(m_select));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] all_outs();
        return {bus.o_select, bus.o_defend, bus.o_attack, bus.o_squat,
                bus.o_jump, bus.o_left, bus.o_right};
    endfunction

    int  pulses [$];
    logic seen;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_key_n     = 7'h7F;
        bus.i_is_gaming = 1'b1;
        rst_n           = 1'b0;
        tick(3);
        chk("reset_outs", int'(all_outs()), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Idle: nothing asserts
        tick(50);
        chk("idle_outs", int'(all_outs()), 0);

        // Jump held: single pulse at edge 6
        bus.i_key_n[2] = 1'b0;
        tick(1);
        tick(5); chk("jump_e5", int'(bus.o_jump), 0);
        tick(1); chk("jump_e6", int'(bus.o_jump), 1);
        tick(1); chk("jump_e7", int'(bus.o_jump), 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin tick(1); seen |= bus.o_jump; end
        chk("jump_hold", int'(seen), 0);
        bus.i_key_n[2] = 1'b1;
        tick(12);

        // Right bouncing with 2-low/1-high period: filtered out
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            bus.i_key_n[0] = ((i % 3) == 2);
            tick(1);
            seen |= bus.o_right;
        end
        bus.i_key_n[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(1); seen |= bus.o_right; end
        chk("glitch_right", int'(seen), 0);

        // Right with 5-cycle lows: accepted, level high edges 6..10
        bus.i_key_n[0] = 1'b0;
        tick(1);
        tick(4); bus.i_key_n[0] = 1'b1;
        tick(1); chk("right5_e5", int'(bus.o_right), 0);
        tick(1); chk("right5_e6", int'(bus.o_right), 1);
        tick(4); chk("right5_e10", int'(bus.o_right), 1);
        tick(1); chk("right5_e11", int'(bus.o_right), 0);
        for (int p = 0; p < 2; p++) begin
            bus.i_key_n[0] = 1'b0; tick(5);
            bus.i_key_n[0] = 1'b1; tick(5);
        end
        tick(10);

        // Right held, then left: both cancel; release right -> left
        bus.i_key_n[0] = 1'b0;
        tick(10);
        chk("rl_right_only", int'({bus.o_right, bus.o_left}), 2);
        bus.i_key_n[1] = 1'b0;
        tick(1);
        tick(5); chk("rl_e5", int'({bus.o_right, bus.o_left}), 2);
        tick(1); chk("rl_both", int'({bus.o_right, bus.o_left}), 0);
        tick(4);
        bus.i_key_n[0] = 1'b1;
        tick(1);
        tick(5); chk("rl_left_e5", int'(bus.o_left), 0);
        tick(1); chk("rl_left_e6", int'({bus.o_right, bus.o_left}), 1);
        bus.i_key_n[1] = 1'b1;
        tick(12);

        // Attack schedule: low 0-9, 12-19, 30-45; pulses expected at 6 and 36
        pulses.delete();
        for (int e = 0; e < 56; e++) begin
            bus.i_key_n[4] = !((e < 10) || (e >= 12 && e < 20) || (e >= 30 && e < 46));
            tick(1);
            if (bus.o_attack) pulses.push_back(e);
        end
        chk("atk_count", pulses.size(), 2);
        if (pulses.size() == 2) begin
            chk("atk_first", pulses[0], 6);
            chk("atk_second", pulses[1], 36);
        end
        tick(15);

        // Re-press lands at edge 16 inside cooldown: dropped; holding past expiry: nothing
        pulses.delete();
        for (int e = 0; e < 56; e++) begin
            bus.i_key_n[4] = !((e < 6) || (e >= 10 && e < 40));
            tick(1);
            if (bus.o_attack) pulses.push_back(e);
        end
        chk("cd_count", pulses.size(), 1);
        if (pulses.size() == 1) chk("cd_first", pulses[0], 6);
        tick(15);

        // Not gaming: select pulses, defend/jump suppressed
        bus.i_is_gaming = 1'b0;
        tick(3);
        bus.i_key_n[6] = 1'b0;
        tick(1);
        tick(5); chk("sel_e5", int'(bus.o_select), 0);
        tick(1); chk("sel_e6", int'(bus.o_select), 1);
        tick(1); chk("sel_e7", int'(bus.o_select), 0);
        bus.i_key_n[5] = 1'b0;
        bus.i_key_n[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin tick(1); seen |= bus.o_defend | bus.o_jump; end
        chk("nogame_def_jump", int'(seen), 0);
        bus.i_is_gaming = 1'b1;
        tick(1); chk("game_defend", int'(bus.o_defend), 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(1); seen |= bus.o_jump; end
        chk("game_no_jump", int'(seen), 0);

        // Reset while defend/jump/select are held
        rst_n = 1'b0;
        #1;
        chk("midrst_outs", int'(all_outs()), 0);
        tick(2);
        chk("midrst_hold", int'(all_outs()), 0);
        rst_n = 1'b1;
        tick(1);
        tick(5); chk("post_rst_e5", int'(all_outs()), 0);
        tick(1); chk("post_rst_e6", int'(all_outs()), 7'b1100100);
        tick(1); chk("post_rst_e7", int'(all_outs()), 7'b0100000);
        bus.i_key_n = 7'h7F;
        tick(20);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
